vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Downstream consumer of the 25 MHz divided clock. Generates 640x480@60 Hz VGA timing, clocked directly by the 25 MHz pixel clock.
- Outputs:
  - hsync and vsync to the connector.
  - video_on, pixel_x and pixel_y to the organ's display/colour logic, which draws the keyboard and the note indicator.
- All outputs are registered and mutually aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low pulses)

Ports:
- I_CLK  in  1  25 MHz pixel clock, taken from the divider's O_CLK
- rst  in  1  asynchronous reset, active-low
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while the pixel is inside the visible area
- pixel_x  out  10  horizontal counter value, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter value, 0..V_TOTAL-1
- line_end  out  1  one-cycle pulse on the last pixel of each line
- frame_end  out  1  one-cycle pulse on the last pixel of each frame

Behaviour:
- Clock and reset: one clock (I_CLK); reset is asynchronous and active-low (rst). Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt, 10 bits each.
- Reset (rst=0, asynchronous, takes effect immediately):
  - h_cnt=0, v_cnt=0, pixel_x=0, pixel_y=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - video_on=0, line_end=0, frame_end=0.
- Counting, each rising edge with rst=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt increments only on h_cnt wrap; at V_TOTAL-1 (with h_cnt wrap) it wraps to 0.
  - No count values outside 0..H_TOTAL-1 or 0..V_TOTAL-1 are ever reached.
- Output pipeline: every output register loads a decode of the pre-edge (h_cnt, v_cnt). Latency is 1 cycle from counter state to pins, and all outputs share the same latency.
  - pixel_x = h_cnt; pixel_y = v_cnt.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL. vsync changes only together with the pixel_x=0 output.
  - line_end = (h_cnt == H_TOTAL-1).
  - frame_end = (h_cnt == H_TOTAL-1) && (v_cnt == V_TOTAL-1).
- After reset release, the first edge presents pixel (0,0) with video_on=1, hsync and vsync inactive.
- Periods:
  - Line = 800 cycles.
  - Frame = 420000 cycles.
  - hsync low for exactly 96 cycles per line.
  - vsync low for exactly 1600 cycles per frame.
- Reset mid-frame: all outputs return to reset values immediately. Counting restarts from (0,0) on the first edge after release, and no partial sync pulse is extended.
- Simultaneous events: on the last pixel of a frame, line_end and frame_end are both asserted in the same cycle.

Test Plan:
- Hold rst=0 for 5 edges -> hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, line_end=0, frame_end=0. Release rst, 1 edge -> pixel_x=0, pixel_y=0, video_on=1.
- Run 1 line:
  - video_on stays high for outputs x=0..639 and drops at x=640.
  - hsync is low for outputs x=656..751 (96 cycles).
  - line_end is high only at x=799.
  - The next output is x=0, y=1.
- Run a full frame:
  - video_on is never high for y>=480.
  - vsync is low exactly for y=490..491 (1600 cycles).
  - frame_end pulses once at (799,524).
  - The next frame_end arrives exactly 420000 cycles later.
- Assert rst asynchronously between edges at (x=300, y=200) -> outputs go to reset values before the next edge. After release, the sequence restarts at (0,0) and the next frame_end comes after 420000 edges.
- Drive a reduced-size instance (H: 8/2/2/2, V: 4/1/1/1, giving H_TOTAL=14, V_TOTAL=7) -> wraps at x=13 and y=6. hsync is low on x=10..11, vsync is low on y=5, and frame_end pulses every 98 cycles.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock. The
// timing is parameterised, so reduced-size instances can be built for
// quick simulation.
//
// Ports:
//   I_CLK      in   1   pixel clock (25 MHz from the divider)
//   rst        in   1   asynchronous reset, active-low
//   hsync      out  1   horizontal sync, asserted level = SYNC_POL
//   vsync      out  1   vertical sync, asserted level = SYNC_POL
//   video_on   out  1   high while the presented pixel is in the visible area
//   pixel_x    out  10  horizontal position, 0..H_TOTAL-1
//   pixel_y    out  10  vertical position, 0..V_TOTAL-1
//   line_end   out  1   one-cycle pulse on the last pixel of each line
//   frame_end  out  1   one-cycle pulse on the last pixel of each frame
//
// Every output is a register that loads a decode of the counter state
// before the edge. All outputs therefore share one cycle of latency and
// stay mutually aligned.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       I_CLK,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;

  // Wrap on ">=" rather than "==" so a counter can never run past the
  // end of its range, even from an unexpected state.
  always_comb begin
    h_wrap = (h_cnt >= H_LAST);
    v_wrap = (v_cnt >= V_LAST);
    h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // The output stage decodes the pre-edge counters. vsync depends only on
  // v_cnt, which changes on the h_cnt wrap, so the new vsync level appears
  // together with pixel_x = 0.
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      pixel_x   <= '0;
      pixel_y   <= '0;
      video_on  <= 1'b0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      pixel_x   <= h_cnt;
      pixel_y   <= v_cnt;
      video_on  <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hsync     <= ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync     <= ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      line_end  <= (h_cnt == H_LAST);
      frame_end <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

endmodule
